rv_parcel_aligner: RTL and testbench
====================================

// Module: rv_parcel_aligner
// PURPOSE
//  Producer side of the RISC-V predecode path: takes fetch packets of 16-bit parcels, finds instruction
//  boundaries (RVC vs 32-bit), carries split 32-bit instructions across packets, and emits up to
//  OUT_SLOTS aligned instructions per cycle with PCs. Sits between the fetch buffer and the class predecoders.
// PARAMETERS
//  PKT_PARCELS  8   16-bit parcels per fetch packet (packet = 16*PKT_PARCELS bits)
//  OUT_SLOTS    4   max instructions emitted per cycle
//  ADDR_W       64  PC width, byte address, bit0 always 0
// PORTS
//  clk          in   1                 clock, rising edge
//  rst          in   1                 asynchronous reset, active-high
//  flush        in   1                 sync discard of all buffered parcels
//  in_valid     in   1                 fetch packet present
//  in_ready     out  1                 packet accepted when in_valid&&in_ready
//  in_data      in   16*PKT_PARCELS    parcels, parcel0 at [15:0]
//  in_pc        in   ADDR_W            PC of parcel0
//  in_start     in   clog2(PKT_PARCELS) first valid parcel (branch target inside packet)
//  in_redirect  in   1                 packet starts new stream; buffered parcels dropped
//  out_valid    out  OUT_SLOTS         per-slot valid, always a contiguous prefix from slot0
//  out_instr    out  32*OUT_SLOTS      instruction; RVC in [15:0], [31:16]=0
//  out_is16     out  OUT_SLOTS         slot holds RVC instruction
//  out_pc       out  ADDR_W*OUT_SLOTS  PC per slot
//  out_ready    in   1                 consumer takes ALL valid slots this cycle
// BEHAVIOUR
//  - Reset: count=0, head_pc=0, out_valid=0, in_ready=1, out_instr/out_is16/out_pc=0.
//  - Buffer: 2*PKT_PARCELS parcels, head at index 0, count in [0,2*PKT_PARCELS], head_pc register.
//  - Length rule: parcel[1:0]!=2'b11 -> 16-bit; ==2'b11 -> 32-bit, needs parcel i+1 present.
//  - Outputs combinational from registers only (no in_* -> out_* path). Slot k valid iff
//    instruction k fully present in buffer and k<OUT_SLOTS. Trailing lone low half of a
//    32-bit instr never valid; it stays as carry.
//  - in_ready = (count <= PKT_PARCELS) from registers; no dependence on out_ready.
//  - Per cycle (non-flush): consumed = parcels of valid slots if out_ready else 0; buffer shifts
//    down by consumed; head_pc += 2*consumed (mod 2^ADDR_W). If accept: parcels
//    in_start..PKT_PARCELS-1 appended at index count-consumed; if buffer empty after shift
//    or in_redirect, head_pc <= in_pc + 2*in_start.
//  - in_redirect on accept: existing contents (incl. consumed-this-cycle leftovers) discarded;
//    new parcels written at index 0; current-cycle output handshake still completes normally.
//  - No contiguity check: non-redirect packets are assumed sequential by fetch contract.
//  - Latency: packet accepted in cycle N visible on out_* in cycle N+1.
//  - flush: next cycle count=0, out_valid=0; flush wins over simultaneous accept and output
//    handshake (packet presented with flush is dropped, in_ready still reported).
//  - Full: count=2*PKT_PARCELS only reachable transiently; in_ready=0 until drained.
//  - out_valid/out_instr stable while out_ready=0 and no flush.
//  - Reset mid-stream: immediate clear, same as reset values.
// STRUCTURE
//  - Package rv_fetch_pkg: PARCEL_W=16, INSTR_W=32, typedef parcel_t, function is_rvc(parcel_t).
//  - Sub-module rv_parcel_len_chain: combinational; from buffer head + count produces per-slot
//    start index, is16, valid, and total parcels consumed. Top holds buffer, count, PC, handshake.
// TESTING
//  1 Reset then packet of 8 RVC (0x0001), pc=0x1000, out_ready=1 -> cycle+1 slots0-3 valid,
//    pcs 0x1000..0x1006; next cycle slots 0x1008..0x100E; then out_valid=0.
//  2 Packet ending with parcel7=0x0013 (32-bit low half) -> not emitted; next packet parcel0=0x0000
//    -> slot0 out_instr=0x00000013, out_is16=0, pc=packet_pc+14.
//  3 out_ready=0 for 3 cycles with full buffer -> in_ready=0 once count>8, outputs stable;
//    release -> drains in order, no parcel lost or duplicated (scoreboard).
//  4 in_start=5, in_redirect=1, in_pc=0x2000 while buffer holds 6 parcels -> old parcels gone,
//    first slot pc=0x200A.
//  5 flush asserted with in_valid=1 and out_ready=1 -> next cycle out_valid=0, count=0, packet lost.
//  6 head_pc=2^ADDR_W-2, two RVC -> second slot pc wraps to 0.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared fetch-path types: 16-bit parcels and the RVC length test used by the
// parcel aligner and its length chain.
package rv_fetch_pkg;

  localparam int PARCEL_W = 16;
  localparam int INSTR_W  = 32;

  typedef logic [PARCEL_W-1:0] parcel_t;

  // Any encoding other than 2'b11 in the low bits is a compressed instruction
  function automatic logic is_rvc(input parcel_t p);
    return p[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/rv_parcel_len_chain.sv
// Walks the parcel buffer from the head and marks where each of the first
// OUT_SLOTS instructions starts, its size, and whether it is fully present.
module rv_parcel_len_chain
  import rv_fetch_pkg::*;
#(
  parameter int BUF_PARCELS = 16,
  parameter int OUT_SLOTS   = 4,
  parameter int CNT_W       = $clog2(BUF_PARCELS + 1)
) (
  input  parcel_t              parcels   [BUF_PARCELS],
  input  logic [CNT_W-1:0]     count,
  output logic [CNT_W-1:0]     start_idx [OUT_SLOTS],
  output logic [OUT_SLOTS-1:0] is16,
  output logic [OUT_SLOTS-1:0] valid,
  output logic [CNT_W-1:0]     consumed
);

  localparam int BIDX_W = $clog2(BUF_PARCELS);

  logic [CNT_W-1:0] pos;
  logic [CNT_W-1:0] len;
  parcel_t          head;
  logic             ok;

  // Once one slot is incomplete every later slot is invalid, which keeps
  // the valid vector a contiguous prefix and leaves a lone low half as carry.
  always_comb begin
    pos      = '0;
    len      = '0;
    head     = '0;
    ok       = 1'b1;
    is16     = '0;
    valid    = '0;
    for (int k = 0; k < OUT_SLOTS; k++) begin
      start_idx[k] = pos;
      head         = (pos < CNT_W'(BUF_PARCELS)) ? parcels[pos[BIDX_W-1:0]] : '0;
      is16[k]      = is_rvc(head);
      len          = is16[k] ? CNT_W'(1) : CNT_W'(2);
      if (ok && ((pos + len) <= count)) begin
        valid[k] = 1'b1;
        pos      = pos + len;
      end else begin
        ok = 1'b0;
      end
    end
    consumed = pos;
  end

endmodule

// File: rtl/rv_parcel_aligner.sv
// Parcel aligner: buffers fetch-packet parcels, carries split 32-bit
// instructions across packets and presents up to OUT_SLOTS aligned instructions.
module rv_parcel_aligner
  import rv_fetch_pkg::*;
#(
  parameter int PKT_PARCELS = 8,
  parameter int OUT_SLOTS   = 4,
  parameter int ADDR_W      = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [PARCEL_W*PKT_PARCELS-1:0] in_data,
  input  logic [ADDR_W-1:0]               in_pc,
  input  logic [$clog2(PKT_PARCELS)-1:0]  in_start,
  input  logic                            in_redirect,
  output logic [OUT_SLOTS-1:0]            out_valid,
  output logic [INSTR_W*OUT_SLOTS-1:0]    out_instr,
  output logic [OUT_SLOTS-1:0]            out_is16,
  output logic [ADDR_W*OUT_SLOTS-1:0]     out_pc,
  input  logic                            out_ready
);

  localparam int BUF_PARCELS = 2 * PKT_PARCELS;
  localparam int CNT_W       = $clog2(BUF_PARCELS + 1);
  localparam int BIDX_W      = $clog2(BUF_PARCELS);
  localparam int PIDX_W      = $clog2(PKT_PARCELS);

  parcel_t              parcels_q [BUF_PARCELS];
  parcel_t              parcels_d [BUF_PARCELS];
  parcel_t              in_parcels [PKT_PARCELS];
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ADDR_W-1:0]    head_pc_q, head_pc_d;

  logic [CNT_W-1:0]     start_idx [OUT_SLOTS];
  logic [OUT_SLOTS-1:0] slot_is16;
  logic [OUT_SLOTS-1:0] slot_valid;
  logic [CNT_W-1:0]     chain_consumed;

  logic [CNT_W-1:0]     consumed;
  logic [CNT_W-1:0]     remaining;
  logic [CNT_W-1:0]     base;
  logic [CNT_W-1:0]     src;
  logic [CNT_W-1:0]     off;
  logic [CNT_W-1:0]     hi_idx;
  logic                 accept;
  parcel_t              lo_parcel;
  parcel_t              hi_parcel;

  rv_parcel_len_chain #(
    .BUF_PARCELS (BUF_PARCELS),
    .OUT_SLOTS   (OUT_SLOTS),
    .CNT_W       (CNT_W)
  ) u_len_chain (
    .parcels   (parcels_q),
    .count     (count_q),
    .start_idx (start_idx),
    .is16      (slot_is16),
    .valid     (slot_valid),
    .consumed  (chain_consumed)
  );

  always_comb begin
    for (int j = 0; j < PKT_PARCELS; j++) begin
      in_parcels[j] = in_data[PARCEL_W*j +: PARCEL_W];
    end
  end

  // Room for a whole packet is judged from the registered count only
  assign in_ready = (count_q <= CNT_W'(PKT_PARCELS));

  always_comb begin
    out_valid = slot_valid;
    out_is16  = slot_is16 & slot_valid;
    out_instr = '0;
    out_pc    = '0;
    hi_idx    = '0;
    lo_parcel = '0;
    hi_parcel = '0;
    for (int k = 0; k < OUT_SLOTS; k++) begin
      if (slot_valid[k]) begin
        hi_idx    = start_idx[k] + CNT_W'(1);
        lo_parcel = parcels_q[start_idx[k][BIDX_W-1:0]];
        hi_parcel = (hi_idx < CNT_W'(BUF_PARCELS)) ? parcels_q[hi_idx[BIDX_W-1:0]] : '0;
        out_instr[INSTR_W*k +: INSTR_W] = slot_is16[k] ?
          {{(INSTR_W-PARCEL_W){1'b0}}, lo_parcel} : {hi_parcel, lo_parcel};
        out_pc[ADDR_W*k +: ADDR_W] = head_pc_q + (ADDR_W'(start_idx[k]) << 1);
      end
    end
  end

  // Shift out consumed parcels, then append the accepted packet behind the
  // survivors (or at index 0 on a redirect, discarding the survivors).
  always_comb begin
    consumed  = out_ready ? chain_consumed : '0;
    remaining = count_q - consumed;
    accept    = in_valid && in_ready;
    base      = in_redirect ? '0 : remaining;
    src       = '0;
    off       = '0;
    for (int i = 0; i < BUF_PARCELS; i++) begin
      src          = CNT_W'(i) + consumed;
      parcels_d[i] = (src < CNT_W'(BUF_PARCELS)) ? parcels_q[src[BIDX_W-1:0]] : '0;
    end
    count_d   = remaining;
    head_pc_d = head_pc_q + (ADDR_W'(consumed) << 1);
    if (accept) begin
      for (int i = 0; i < BUF_PARCELS; i++) begin
        off = CNT_W'(i) - base + CNT_W'(in_start);
        if ((CNT_W'(i) >= base) && (off < CNT_W'(PKT_PARCELS))) begin
          parcels_d[i] = in_parcels[off[PIDX_W-1:0]];
        end
      end
      count_d = base + CNT_W'(PKT_PARCELS) - CNT_W'(in_start);
      if ((remaining == '0) || in_redirect) begin
        head_pc_d = in_pc + (ADDR_W'(in_start) << 1);
      end
    end
    if (flush) begin
      parcels_d = parcels_q;
      count_d   = '0;
      head_pc_d = head_pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      head_pc_q <= '0;
      for (int i = 0; i < BUF_PARCELS; i++) begin
        parcels_q[i] <= '0;
      end
    end else begin
      count_q   <= count_d;
      head_pc_q <= head_pc_d;
      for (int i = 0; i < BUF_PARCELS; i++) begin
        parcels_q[i] <= parcels_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rv_parcel_aligner.sv
// Bench for rv_parcel_aligner: a parcel-queue model checked every cycle plus
// directed scenarios with literal expectations.
module tb_rv_parcel_aligner;

  localparam int PKT   = 8;
  localparam int SLOTS = 4;
  localparam int AW    = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [16*PKT-1:0] in_data;
  logic [AW-1:0]     in_pc;
  logic [2:0]        in_start;
  logic              in_redirect;
  logic [SLOTS-1:0]  out_valid;
  logic [32*SLOTS-1:0] out_instr;
  logic [SLOTS-1:0]  out_is16;
  logic [AW*SLOTS-1:0] out_pc;
  logic              out_ready;

  int checks = 0;
  int errors = 0;

  logic [15:0] mq[$];
  logic [AW-1:0] mpc;
  logic [15:0] pk [PKT];

  always #5 clk = ~clk;

  rv_parcel_aligner #(.PKT_PARCELS(PKT), .OUT_SLOTS(SLOTS), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_pc       (in_pc),
    .in_start    (in_start),
    .in_redirect (in_redirect),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_is16    (out_is16),
    .out_pc      (out_pc),
    .out_ready   (out_ready)
  );

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int plen(input logic [15:0] p);
    return (p[1:0] == 2'b11) ? 2 : 1;
  endfunction

  // Start index of instruction k in the model queue, or -1 if not complete
  function automatic int slot_start(input int k);
    int p = 0;
    for (int j = 0; j <= k; j++) begin
      if (p >= mq.size()) return -1;
      if (p + plen(mq[p]) > mq.size()) return -1;
      if (j == k) return p;
      p += plen(mq[p]);
    end
    return -1;
  endfunction

  function automatic int model_consumed();
    int n = 0;
    for (int k = 0; k < SLOTS; k++) begin
      int s;
      s = slot_start(k);
      if (s >= 0) n = s + plen(mq[s]);
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    int  cons;
    bit  acc;
    if (rst) begin
      mq.delete();
      mpc = '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      cons = out_ready ? model_consumed() : 0;
      acc  = in_valid && (mq.size() <= PKT);
      repeat (cons) void'(mq.pop_front());
      mpc = mpc + 64'(2 * cons);
      if (acc) begin
        if (in_redirect) mq.delete();
        if (mq.size() == 0 || in_redirect) mpc = in_pc + 64'(2 * int'(in_start));
        for (int j = int'(in_start); j < PKT; j++) mq.push_back(in_data[16*j +: 16]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check_val("in_ready", 64'(in_ready), 64'(mq.size() <= PKT));
      for (int k = 0; k < SLOTS; k++) begin
        int s;
        logic [31:0] ei;
        s = slot_start(k);
        check_val($sformatf("slot%0d_valid", k), 64'(out_valid[k]), 64'(s >= 0));
        if (s >= 0 && out_valid[k]) begin
          ei = (plen(mq[s]) == 2) ? {mq[s+1], mq[s]} : {16'h0000, mq[s]};
          check_val($sformatf("slot%0d_instr", k), 64'(out_instr[32*k +: 32]), 64'(ei));
          check_val($sformatf("slot%0d_is16", k), 64'(out_is16[k]), 64'(plen(mq[s]) == 1));
          check_val($sformatf("slot%0d_pc", k), out_pc[AW*k +: AW], mpc + 64'(2 * s));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [63:0] pc, input int start, input logic redir,
                                input logic valid);
    in_pc       = pc;
    in_start    = 3'(start);
    in_redirect = redir;
    in_valid    = valid;
    for (int j = 0; j < PKT; j++) in_data[16*j +: 16] = pk[j];
  endtask

  task automatic check_output(input string name, input int k, input logic [31:0] ei,
                              input logic [63:0] ep);
    check_val({name, "_v"}, 64'(out_valid[k]), 64'd1);
    check_val({name, "_instr"}, 64'(out_instr[32*k +: 32]), 64'(ei));
    check_val({name, "_pc"}, out_pc[AW*k +: AW], ep);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  accepted;
    int  drained;
    flush = 0; in_valid = 0; in_redirect = 0; in_start = 0; in_pc = 0; in_data = '0;
    out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", 64'(out_valid), 64'd0);
    check_val("rst_ready", 64'(in_ready), 64'd1);
    check_val("rst_instr", 64'(out_instr[63:0]), 64'd0);
    check_val("rst_pc", out_pc[63:0], 64'd0);
    check_val("rst_is16", 64'(out_is16), 64'd0);
    rst = 0;
    step();

    // Eight compressed instructions drain four per cycle
    for (int j = 0; j < PKT; j++) pk[j] = 16'h0001;
    apply_stimulus(64'h1000, 0, 0, 1);
    step();
    in_valid = 0;
    check_val("t1_valid", 64'(out_valid), 64'hF);
    for (int k = 0; k < SLOTS; k++) check_output("t1a", k, 32'h1, 64'h1000 + 64'(2 * k));
    step();
    for (int k = 0; k < SLOTS; k++) check_output("t1b", k, 32'h1, 64'h1008 + 64'(2 * k));
    step();
    check_val("t1_empty", 64'(out_valid), 64'd0);

    // A 32-bit instruction split across two packets
    for (int j = 0; j < 7; j++) pk[j] = 16'h0001 | 16'(j << 8);
    pk[7] = 16'h0013;
    apply_stimulus(64'h3000, 0, 0, 1);
    step();
    in_valid = 0;
    step();
    check_val("t2_carry_valid", 64'(out_valid), 64'h7);
    check_output("t2_s2", 2, 32'h0601, 64'h300C);
    pk[0] = 16'h0000;
    for (int j = 1; j < PKT; j++) pk[j] = 16'h0001 | 16'(j << 12);
    apply_stimulus(64'h3010, 0, 0, 1);
    step();
    in_valid = 0;
    check_output("t2_join", 0, 32'h0000_0013, 64'h300E);
    check_val("t2_join_is16", 64'(out_is16[0]), 64'd0);
    check_output("t2_s1", 1, 32'h1001, 64'h3012);
    check_val("t2_ready", 64'(in_ready), 64'd0);
    repeat (4) step();

    // Back-pressure fills the buffer; it must hold and then drain in order
    out_ready = 0;
    pk[0] = 16'h0001; pk[1] = 16'h0005; pk[2] = 16'h0013; pk[3] = 16'h1111;
    pk[4] = 16'h0009; pk[5] = 16'h000D; pk[6] = 16'h0011; pk[7] = 16'h0015;
    apply_stimulus(64'h5000, 0, 0, 1);
    step();
    check_val("t3_ready_half", 64'(in_ready), 64'd1);
    for (int j = 0; j < PKT; j++) pk[j] = 16'h0021 | 16'(j << 8);
    apply_stimulus(64'h5010, 0, 0, 1);
    step();
    for (int j = 0; j < PKT; j++) pk[j] = 16'h0031 | 16'(j << 8);
    apply_stimulus(64'h5020, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      check_val("t3_full_ready", 64'(in_ready), 64'd0);
      check_val("t3_hold_valid", 64'(out_valid), 64'hF);
      check_output("t3_hold_s2", 2, 32'h1111_0013, 64'h5004);
      check_val("t3_hold_is16", 64'(out_is16), 64'hB);
      step();
    end
    out_ready = 1;
    accepted = 0;
    for (int c = 0; c < 20; c++) begin
      if (in_ready) begin
        step();
        accepted = 1;
        break;
      end
      step();
    end
    check_val("t3_accept", 64'(accepted), 64'd1);
    in_valid = 0;
    drained = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid == '0) begin
        drained = 1;
        break;
      end
      step();
    end
    check_val("t3_drain", 64'(drained), 64'd1);

    // Redirect into the middle of a packet discards buffered parcels
    out_ready = 0;
    for (int j = 0; j < PKT; j++) pk[j] = 16'h0041 | 16'(j << 8);
    apply_stimulus(64'h4000, 2, 0, 1);
    step();
    check_output("t4_pre", 0, 32'h0241, 64'h4004);
    for (int j = 0; j < 5; j++) pk[j] = 16'hBEE3;
    pk[5] = 16'h0A01; pk[6] = 16'h0B01; pk[7] = 16'h0C01;
    apply_stimulus(64'h2000, 5, 1, 1);
    out_ready = 1;
    step();
    in_valid = 0; in_redirect = 0; in_start = 0;
    check_val("t4_valid", 64'(out_valid), 64'h7);
    check_output("t4_s0", 0, 32'h0A01, 64'h200A);
    check_output("t4_s1", 1, 32'h0B01, 64'h200C);
    check_output("t4_s2", 2, 32'h0C01, 64'h200E);

    // Flush beats a simultaneous accept and output handshake
    check_val("t5_ready", 64'(in_ready), 64'd1);
    for (int j = 0; j < PKT; j++) pk[j] = 16'h0051 | 16'(j << 8);
    apply_stimulus(64'h6000, 0, 0, 1);
    flush = 1;
    step();
    flush = 0; in_valid = 0;
    check_val("t5_valid", 64'(out_valid), 64'd0);
    check_val("t5_ready_after", 64'(in_ready), 64'd1);
    step();
    check_val("t5_lost", 64'(out_valid), 64'd0);

    // PC wraps past the top of the address space
    out_ready = 0;
    for (int j = 0; j < PKT; j++) pk[j] = 16'h0041;
    pk[7] = 16'h0071;
    apply_stimulus(64'hFFFF_FFFF_FFFF_FFF0, 7, 0, 1);
    step();
    for (int j = 0; j < PKT; j++) pk[j] = 16'h0081 | 16'(j << 8);
    apply_stimulus(64'h0, 0, 0, 1);
    step();
    in_valid = 0; in_start = 0;
    check_val("t6_valid", 64'(out_valid), 64'hF);
    check_output("t6_s0", 0, 32'h0071, 64'hFFFF_FFFF_FFFF_FFFE);
    check_output("t6_s1", 1, 32'h0081, 64'h0);
    check_output("t6_s2", 2, 32'h0181, 64'h2);
    out_ready = 1;
    repeat (4) step();

    // Mixed traffic with stalls, redirects and a flush, checked by the model
    for (int c = 0; c < 48; c++) begin
      for (int j = 0; j < PKT; j++) begin
        logic [15:0] p;
        p = 16'(c * 37 + j * 11);
        if (j == 3 || (c + j) % 5 == 0) p[1:0] = 2'b11;
        else if (p[1:0] == 2'b11) p[1:0] = 2'b01;
        pk[j] = p;
      end
      apply_stimulus(64'h8000 + 64'(c * 16), (c % 7 == 0) ? c % 8 : 0, (c % 9 == 4), (c % 3 != 2));
      out_ready = (c % 4 != 3);
      flush = (c == 30);
      step();
    end
    flush = 0; in_valid = 0; in_redirect = 0; in_start = 0; out_ready = 1;
    repeat (12) step();

    // Reset in the middle of a stream clears everything at once
    out_ready = 0;
    for (int j = 0; j < PKT; j++) pk[j] = 16'h0001;
    apply_stimulus(64'h9000, 0, 1, 1);
    step();
    in_valid = 0; in_redirect = 0;
    check_val("t8_loaded", 64'(out_valid), 64'hF);
    #2 rst = 1;
    #1;
    check_val("t8_rst_valid", 64'(out_valid), 64'd0);
    check_val("t8_rst_ready", 64'(in_ready), 64'd1);
    check_val("t8_rst_pc", out_pc[63:0], 64'd0);
    check_val("t8_rst_instr", 64'(out_instr[63:0]), 64'd0);
    @(posedge clk);
    #1 rst = 0;
    out_ready = 1;
    step();
    check_val("t8_after", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
